// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// mult/div front-end hold and fixed-length CP0 exception flush.
module pipe_hazard_ctrl #(
   parameter int MULT_CYCLES      = 4,
   parameter int DIV_CYCLES       = 32,
   parameter int EXC_FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_ra,
   input  logic [4:0] id_rb,
   input  logic       id_useA,
   input  logic       id_useB,
   input  logic [4:0] ex_rw,
   input  logic       ex_regWr,
   input  logic [1:0] ex_memtoreg,
   input  logic       id_md_start,
   input  logic       id_md_div,
   input  logic       ex_branch_taken,
   input  logic       cp0_exc,
   output logic       hazard,
   output logic       BranchBubble,
   output logic [1:0] cp0bubble,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       md_busy,
   output logic       md_done,
   output logic       md_abort,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MD_WAIT   = 2'd1,
      EXC_FLUSH = 2'd2,
      ILLEGAL   = 2'd3
   } stateT;

   localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);
   localparam logic [5:0] EXC_LOAD  = 6'(EXC_FLUSH_CYCLES - 1);
   localparam logic       EXC_SKIP  = (EXC_FLUSH_CYCLES == 1);

   stateT      r_state;
   stateT      w_nextState;
   logic [5:0] r_cnt;
   logic [5:0] w_nextCnt;
   logic       r_mdDone;
   logic       w_nextMdDone;
   logic       w_loadUse;

   assign w_loadUse = ex_regWr && (ex_memtoreg == 2'b01) && (ex_rw != 5'd0) &&
                      ((id_useA && (id_ra == ex_rw)) || (id_useB && (id_rb == ex_rw)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= RUN;
         r_cnt    <= 6'd0;
         r_mdDone <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_mdDone <= w_nextMdDone;
      end
   end

   // A CP0 event always lands in the same flush sequence, whatever state it interrupts.
   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_nextMdDone = 1'b0;
      hazard       = 1'b0;
      BranchBubble = 1'b0;
      cp0bubble    = 2'd0;
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      md_busy      = 1'b0;
      md_abort     = 1'b0;
      case (r_state)
         RUN: begin
            if (cp0_exc) begin
               BranchBubble = 1'b1;
               cp0bubble    = 2'd1;
               ifid_flush   = 1'b1;
               w_nextState  = EXC_SKIP ? RUN : EXC_FLUSH;
               w_nextCnt    = EXC_LOAD;
            end else if (ex_branch_taken) begin
               BranchBubble = 1'b1;
               ifid_flush   = 1'b1;
            end else if (id_md_start) begin
               w_nextState = MD_WAIT;
               w_nextCnt   = id_md_div ? DIV_LOAD : MULT_LOAD;
            end else if (w_loadUse) begin
               hazard     = 1'b1;
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
            end
         end
         MD_WAIT: begin
            md_busy    = 1'b1;
            hazard     = 1'b1;
            ifid_stall = 1'b1;
            if (cp0_exc) begin
               md_abort     = 1'b1;
               BranchBubble = 1'b1;
               cp0bubble    = 2'd1;
               ifid_flush   = 1'b1;
               w_nextState  = EXC_SKIP ? RUN : EXC_FLUSH;
               w_nextCnt    = EXC_LOAD;
            end else begin
               pc_stall = 1'b1;
               if (r_cnt == 6'd0) begin
                  w_nextState  = RUN;
                  w_nextMdDone = 1'b1;
               end else begin
                  w_nextCnt = r_cnt - 6'd1;
               end
            end
         end
         EXC_FLUSH: begin
            BranchBubble = 1'b1;
            cp0bubble    = 2'd1;
            ifid_flush   = 1'b1;
            if (cp0_exc) begin
               w_nextState = EXC_SKIP ? RUN : EXC_FLUSH;
               w_nextCnt   = EXC_LOAD;
            end else if (r_cnt == 6'd0) begin
               w_nextState = RUN;
            end else begin
               w_nextCnt = r_cnt - 6'd1;
            end
         end
         default: begin
            w_nextState = RUN;
            w_nextCnt   = 6'd0;
         end
      endcase
   end

   assign md_done = r_mdDone;
   assign state   = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   localparam int MULT = 4;
   localparam int DIV  = 32;
   localparam int EXC  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_ra, id_rb, ex_rw;
   logic       id_useA, id_useB, ex_regWr;
   logic [1:0] ex_memtoreg;
   logic       id_md_start, id_md_div, ex_branch_taken, cp0_exc;
   logic       hazard, BranchBubble, pc_stall, ifid_stall, ifid_flush;
   logic       md_busy, md_done, md_abort;
   logic [1:0] cp0bubble, state;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining cycles of each hold, counted down from the event.
   int busyLeft  = 0;
   int flushLeft = 0;
   bit doneNow   = 1'b0;

   pipe_hazard_ctrl #(
      .MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .EXC_FLUSH_CYCLES(EXC)
   ) dut (
      .clk(clk), .rst(rst),
      .id_ra(id_ra), .id_rb(id_rb), .id_useA(id_useA), .id_useB(id_useB),
      .ex_rw(ex_rw), .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg),
      .id_md_start(id_md_start), .id_md_div(id_md_div),
      .ex_branch_taken(ex_branch_taken), .cp0_exc(cp0_exc),
      .hazard(hazard), .BranchBubble(BranchBubble), .cp0bubble(cp0bubble),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .md_busy(md_busy), .md_done(md_done), .md_abort(md_abort), .state(state)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int flushLen();
      return (EXC == 1) ? 0 : EXC;
   endfunction

   // Drive one cycle of inputs, compare every output to the model, then advance the model.
   task automatic applyStimulus(input logic [4:0] ra, input logic [4:0] rb, input logic ua, input logic ub,
                                input logic [4:0] rw, input logic wr, input logic [1:0] mtr,
                                input logic mds, input logic mdd, input logic br, input logic cp0);
      bit lu;
      bit eHaz, eBB, ePc, eIfs, eFl, eBusy, eAbort;
      int eCp, eState;
      bit newDone;
      @(negedge clk);
      id_ra = ra; id_rb = rb; id_useA = ua; id_useB = ub;
      ex_rw = rw; ex_regWr = wr; ex_memtoreg = mtr;
      id_md_start = mds; id_md_div = mdd; ex_branch_taken = br; cp0_exc = cp0;
      #1;
      lu = wr && (mtr == 2'b01) && (rw != 0) && ((ua && ra == rw) || (ub && rb == rw));
      {eHaz, eBB, ePc, eIfs, eFl, eBusy, eAbort} = '0;
      eCp = 0;
      if (flushLeft > 0) begin
         eState = 2; eBB = 1; eCp = 1; eFl = 1;
      end else if (busyLeft > 0) begin
         eState = 1; eBusy = 1; eHaz = 1; eIfs = 1;
         if (cp0) begin eAbort = 1; eBB = 1; eCp = 1; eFl = 1; end
         else ePc = 1;
      end else begin
         eState = 0;
         if (cp0) begin eBB = 1; eCp = 1; eFl = 1; end
         else if (br) begin eBB = 1; eFl = 1; end
         else if (!mds && lu) begin eHaz = 1; ePc = 1; eIfs = 1; end
      end
      checkOutput("state", 8'(state), 8'(eState));
      checkOutput("hazard", 8'(hazard), 8'(eHaz));
      checkOutput("BranchBubble", 8'(BranchBubble), 8'(eBB));
      checkOutput("cp0bubble", 8'(cp0bubble), 8'(eCp));
      checkOutput("pc_stall", 8'(pc_stall), 8'(ePc));
      checkOutput("ifid_stall", 8'(ifid_stall), 8'(eIfs));
      checkOutput("ifid_flush", 8'(ifid_flush), 8'(eFl));
      checkOutput("md_busy", 8'(md_busy), 8'(eBusy));
      checkOutput("md_abort", 8'(md_abort), 8'(eAbort));
      checkOutput("md_done", 8'(md_done), 8'(doneNow));
      newDone = 1'b0;
      if (flushLeft > 0) begin
         flushLeft = cp0 ? flushLen() : flushLeft - 1;
      end else if (busyLeft > 0) begin
         if (cp0) begin
            busyLeft  = 0;
            flushLeft = flushLen();
         end else begin
            busyLeft--;
            newDone = (busyLeft == 0);
         end
      end else if (cp0) begin
         flushLeft = flushLen();
      end else if (!br && mds) begin
         busyLeft = mdd ? DIV : MULT;
      end
      doneNow = newDone;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_state"}, 8'(state), 8'd0);
      checkOutput({tag, "_outs"}, 8'({hazard, BranchBubble, cp0bubble, pc_stall, ifid_stall,
                                      ifid_flush, md_busy}), 8'd0);
      checkOutput({tag, "_md"}, 8'({md_done, md_abort}), 8'd0);
   endtask

   initial begin
      rst = 1'b1;
      {id_ra, id_rb, ex_rw} = '0;
      {id_useA, id_useB, ex_regWr, id_md_start, id_md_div, ex_branch_taken, cp0_exc} = '0;
      ex_memtoreg = 2'd0;
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Load-use on rs, then the same with destination $0.
      applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      idleCycles(1);

      // mult: four busy cycles then a done pulse.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(7);

      // div aborted by an exception on its tenth busy cycle.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(9);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idleCycles(4);

      // Branch together with load-use, then exception together with branch.
      applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      idleCycles(4);

      // Reset asserted mid-divide once the counter has reached 17.
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      idleCycles(14);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkAllZero("midmd_rst");
      @(negedge clk);
      rst = 1'b0;
      busyLeft = 0; flushLeft = 0; doneNow = 1'b0;
      idleCycles(3);

      // Random traffic with narrow register ranges so hazards occur often.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                       5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 23) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives the `hazard`, `BranchBubble` and `cp0bubble` inputs of the ID/EX pipeline register.
- Also drives the PC and IF/ID stall/flush controls.
- Detects load-use hazards and taken branches/jumps resolved in EX.
- Holds the front end while the multi-cycle mult/div unit runs, and sequences a fixed-length flush on CP0 exception/eret.

Parameters:
- MULT_CYCLES, 4, EX-hold length for mult/multu (1..63)
- DIV_CYCLES, 32, EX-hold length for div/divu (1..63)
- EXC_FLUSH_CYCLES, 2, bubble cycles forced after a CP0 event (1..63)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id_ra  in  5  rs of instruction in ID
- id_rb  in  5  rt of instruction in ID
- id_useA  in  1  ID instruction reads rs
- id_useB  in  1  ID instruction reads rt
- ex_rw  in  5  destination register of instruction in EX
- ex_regWr  in  1  EX instruction writes register file
- ex_memtoreg  in  2  EX writeback source; 2'b01 = load
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_div  in  1  qualifies id_md_start: 1 = divide
- ex_branch_taken  in  1  branch/jump redirect resolved in EX this cycle
- cp0_exc  in  1  exception or eret detected this cycle
- hazard  out  1  to ID/EX: insert bubble (stall)
- BranchBubble  out  1  to ID/EX: insert bubble (flush)
- cp0bubble  out  2  to ID/EX: 2'd1 squashes ex_cp0op
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to nop
- md_busy  out  1  mult/div hold in progress
- md_done  out  1  one-cycle pulse, registered, when hold ends
- md_abort  out  1  one-cycle pulse, combinational, when a CP0 event kills a running mult/div
- state  out  2  debug: 0 RUN, 1 MD_WAIT, 2 EXC_FLUSH

Behaviour:
- Async reset:
  - state=RUN, 6-bit counter cnt=0, md_done=0.
  - All outputs are 0 while inputs are idle.
- All outputs except md_done and state are combinational from state, cnt and inputs.
- Event priority within a cycle: cp0_exc > ex_branch_taken > id_md_start > load-use.
- load_use = ex_regWr && ex_memtoreg==2'b01 && ex_rw!=0 && ((id_useA && id_ra==ex_rw) || (id_useB && id_rb==ex_rw)).
- RUN:
  - cp0_exc:
    - BranchBubble=1, cp0bubble=1, ifid_flush=1, pc_stall=0.
    - Next: EXC_FLUSH with cnt=EXC_FLUSH_CYCLES-1; if EXC_FLUSH_CYCLES==1, stay RUN.
  - ex_branch_taken:
    - BranchBubble=1, ifid_flush=1, pc_stall=0.
    - Stays RUN; the load_use stall is suppressed.
  - id_md_start (no higher event):
    - No stall this cycle; the md instruction enters EX at the edge.
    - Next: MD_WAIT with cnt=(id_md_div ? DIV_CYCLES : MULT_CYCLES)-1.
  - load_use only: hazard=1, pc_stall=1, ifid_stall=1 for exactly this cycle; next cycle re-evaluates.
- MD_WAIT:
  - md_busy=1, hazard=1, pc_stall=1, ifid_stall=1.
  - cnt decrements each edge. On the edge where cnt==0: state→RUN, md_done=1 for the following cycle.
  - load_use and ex_branch_taken are ignored (EX holds only bubbles).
  - cp0_exc preempts: md_abort=1 that cycle, flush outputs as in RUN, next EXC_FLUSH; md_done never pulses.
- EXC_FLUSH:
  - BranchBubble=1, cp0bubble=1, ifid_flush=1; PC free-runs from the vector.
  - cnt decrements; at cnt==0 → RUN.
  - cp0_exc here reloads cnt=EXC_FLUSH_CYCLES-1 (restart).
  - id_md_start, branch and load_use are ignored.
- hazard and BranchBubble may both be 1 only if an exception arrives in MD_WAIT; the ID/EX register treats this as a bubble.
- ifid_flush overrides ifid_stall when both are 1.
- Reset mid-MD or mid-flush returns to RUN immediately; no md_done.
- state encoding 3 is illegal; it must recover to RUN on the next edge.

Test Plan:
- lw $5 in EX (ex_regWr=1, ex_memtoreg=01, ex_rw=5); ID add reads id_ra=5, id_useA=1 → hazard=pc_stall=ifid_stall=1 for 1 cycle; same case with ex_rw=0 → no stall.
- mult in ID (id_md_start=1, id_md_div=0), MULT_CYCLES=4 → md_busy=1 for 4 cycles starting the next cycle, then md_done=1 for 1 cycle, state back to 0.
- div with DIV_CYCLES=32; cp0_exc at the 10th busy cycle → md_abort=1 that cycle, state=2 for 2 cycles with BranchBubble=1 and cp0bubble=1, no md_done.
- ex_branch_taken=1 together with a load_use condition → BranchBubble=1, ifid_flush=1, hazard=0, pc_stall=0.
- cp0_exc and ex_branch_taken in the same RUN cycle → exception path wins: cp0bubble=1, state=2 next cycle.
- Assert rst during MD_WAIT with cnt=17 → all outputs 0 immediately, state=0, md_done stays 0 after release.
